// File: rtl/box_pkg.sv
// Shared sample type and sizing limits for the box-filter encode/decode pair.
package box_pkg;
  localparam int unsigned SAMPLE_WIDTH    = 32;
  localparam int unsigned MAX_FILTER_SIZE = 64;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
endpackage

// File: rtl/box_sum_decoder_if.sv
// Sample stream bundle: window sums in, reconstructed samples out.
interface box_sum_decoder_if;
  import box_pkg::*;

  logic    in_valid;
  sample_t in;
  logic    out_valid;
  sample_t out;

  modport master (output in_valid, output in, input out_valid, input out);
  modport slave  (input in_valid, input in, output out_valid, output out);
endinterface

// File: rtl/box_history.sv
// N-entry ring of past samples; rdata is always the oldest entry, at the write pointer.
module box_history
  import box_pkg::*;
#(
  parameter int unsigned FILTER_SIZE = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    we,
  input  sample_t wdata,
  output sample_t rdata
);

  localparam int unsigned PtrW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(FILTER_SIZE - 1);

  logic [PtrW-1:0] wp_q, wp_d;
  sample_t         hist_q [FILTER_SIZE];
  sample_t         hist_d [FILTER_SIZE];

  always_comb begin
    wp_d   = wp_q;
    hist_d = hist_q;
    if (we) begin
      hist_d[wp_q] = wdata;
      wp_d         = (wp_q == LastIdx) ? '0 : wp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q   <= '0;
      hist_q <= '{default: '0};
    end else begin
      wp_q   <= wp_d;
      hist_q <= hist_d;
    end
  end

  // Read-before-write: the caller sees the entry being overwritten this cycle.
  assign rdata = hist_q[wp_q];

endmodule

// File: rtl/box_sum_decoder.sv
// Inverts a FILTER_SIZE-sample running sum: x[n] = s[n] - s[n-1] + x[n-N], mod 2^32.
module box_sum_decoder
  import box_pkg::*;
#(
  parameter int unsigned FILTER_SIZE = 4
) (
  input logic              clk,
  input logic              rst,
  box_sum_decoder_if.slave bus
);

  if (FILTER_SIZE < 1 || FILTER_SIZE > MAX_FILTER_SIZE) begin : gen_size_check
    $error("box_sum_decoder: FILTER_SIZE out of range 1..%0d", MAX_FILTER_SIZE);
  end

  sample_t prev_sum_q, prev_sum_d;
  sample_t out_q, out_d;
  logic    out_valid_q, out_valid_d;
  sample_t oldest;
  sample_t x;

  assign x = bus.in - prev_sum_q + oldest;

  box_history #(
    .FILTER_SIZE(FILTER_SIZE)
  ) u_history (
    .clk  (clk),
    .rst  (rst),
    .we   (bus.in_valid),
    .wdata(x),
    .rdata(oldest)
  );

  always_comb begin
    prev_sum_d  = prev_sum_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      prev_sum_d  = bus.in;
      out_d       = x;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sum_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      prev_sum_q  <= prev_sum_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
